// File: rtl/read_arbiter_pkg.sv
// Shared types for the copperv read arbiter: FSM state encoding and requester IDs.
package copperv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/read_arbiter_if.sv
// One read channel: address valid/ready plus data valid/ready.
// The master drives the address and accepts the data; the slave does the opposite.
interface read_arbiter_if #(
    parameter int bus_width = 32
);
    logic                 raddr_valid;
    logic [bus_width-1:0] raddr;
    logic                 raddr_ready;
    logic                 rdata_valid;
    logic [bus_width-1:0] rdata;
    logic                 rdata_ready;

    modport master (
        output raddr_valid, raddr, rdata_ready,
        input  raddr_ready, rdata_valid, rdata
    );

    modport slave (
        input  raddr_valid, raddr, rdata_ready,
        output raddr_ready, rdata_valid, rdata
    );
endinterface

// File: rtl/read_arbiter_rr.sv
// Combinational 2-way grant, one-hot, indexed by requester ID.
// READ_ARB_DATA_PRIO_EN selects fixed data-first priority instead of round-robin.
module rr_arbiter_2
    import copperv_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

`ifdef READ_ARB_DATA_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
    assign o_grant[REQ_D] = i_req_d;
    assign o_grant[REQ_I] = i_req_i & ~i_req_d;
`else
    // On a tie the requester that was not served last wins.
    assign o_grant[REQ_I] = i_req_i & (~i_req_d | (i_last_grant == REQ_D));
    assign o_grant[REQ_D] = i_req_d & (~i_req_i | (i_last_grant == REQ_I));
`endif

endmodule

// File: rtl/read_arbiter.sv
// Shares one memory read port between instruction and data requesters, one read in flight.
// Optional build macro: READ_ARB_DATA_PRIO_EN (data requester always wins ties).
module read_arbiter
    import copperv_pkg::*;
#(
    parameter int bus_width = 32
) (
    input  logic           clk,
    input  logic           rst,
    read_arbiter_if.slave  i_port,
    read_arbiter_if.slave  d_port,
    read_arbiter_if.master m_port
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_owner;
    logic                 r_last_grant;
    logic [bus_width-1:0] r_addr_q;
    logic [1:0]           w_grant;
    logic                 w_take;

    rr_arbiter_2 u_rr (
        .i_req_i      (i_port.raddr_valid),
        .i_req_d      (d_port.raddr_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= REQ_I;
            r_last_grant <= REQ_D;
            r_addr_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_addr_q     <= w_grant[REQ_D] ? d_port.raddr : i_port.raddr;
                r_owner      <= w_grant[REQ_D] ? REQ_D : REQ_I;
                r_last_grant <= w_grant[REQ_D] ? REQ_D : REQ_I;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt         = r_state;
        w_take              = 1'b0;
        i_port.raddr_ready  = 1'b0;
        d_port.raddr_ready  = 1'b0;
        i_port.rdata_valid  = 1'b0;
        d_port.rdata_valid  = 1'b0;
        i_port.rdata        = m_port.rdata;
        d_port.rdata        = m_port.rdata;
        m_port.raddr_valid  = 1'b0;
        m_port.raddr        = r_addr_q;
        m_port.rdata_ready  = 1'b0;

        // Holding reset gates every handshake so an abandoned transaction cannot complete.
        if (rst) begin
            unique case (r_state)
                IDLE: begin
                    i_port.raddr_ready = w_grant[REQ_I];
                    d_port.raddr_ready = w_grant[REQ_D];
                    if (|w_grant) begin
                        w_take      = 1'b1;
                        w_state_nxt = ADDR;
                    end
                end
                ADDR: begin
                    m_port.raddr_valid = 1'b1;
                    if (m_port.raddr_ready) w_state_nxt = DATA;
                end
                DATA: begin
                    if (r_owner == REQ_D) begin
                        d_port.rdata_valid = m_port.rdata_valid;
                        m_port.rdata_ready = d_port.rdata_ready;
                    end else begin
                        i_port.rdata_valid = m_port.rdata_valid;
                        m_port.rdata_ready = i_port.rdata_ready;
                    end
                    if (m_port.rdata_valid && m_port.rdata_ready) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// Directed self-checking bench for read_arbiter; expectations follow READ_ARB_DATA_PRIO_EN.
module tb_read_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    read_arbiter_if #(.bus_width(32)) i_if ();
    read_arbiter_if #(.bus_width(32)) d_if ();
    read_arbiter_if #(.bus_width(32)) m_if ();

    read_arbiter #(.bus_width(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_port (i_if),
        .d_port (d_if),
        .m_port (m_if)
    );

    always #5 clk = ~clk;

    // Owner of each of the four contended transactions, bit k = transaction k (1 = D).
`ifdef READ_ARB_DATA_PRIO_EN
    localparam logic [3:0] CONT_OWNER = 4'b1111;
`else
    localparam logic [3:0] CONT_OWNER = 4'b1010;
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in IDLE with the expected winner's request pending; leaves in IDLE.
    task automatic xact(input string tag, input logic [31:0] addr, input logic owner_d,
                        input logic [31:0] data);
        check_b({tag, " i_raddr_ready"}, i_if.raddr_ready, !owner_d);
        check_b({tag, " d_raddr_ready"}, d_if.raddr_ready, owner_d);
        cyc();
        check_b({tag, " m_raddr_valid"}, m_if.raddr_valid, 1'b1);
        check_w({tag, " m_raddr"}, m_if.raddr, addr);
        check_b({tag, " ready while busy"}, i_if.raddr_ready | d_if.raddr_ready, 1'b0);
        cyc();
        m_if.rdata_valid = 1'b1;
        m_if.rdata       = data;
        #1;
        check_b({tag, " owner rdata_valid"}, owner_d ? d_if.rdata_valid : i_if.rdata_valid, 1'b1);
        check_w({tag, " owner rdata"}, owner_d ? d_if.rdata : i_if.rdata, data);
        check_b({tag, " other rdata_valid"}, owner_d ? i_if.rdata_valid : d_if.rdata_valid, 1'b0);
        check_b({tag, " m_rdata_ready"}, m_if.rdata_ready, 1'b1);
        cyc();
        m_if.rdata_valid = 1'b0;
        #1;
        check_b({tag, " back to idle"}, m_if.raddr_valid, 1'b0);
    endtask

    initial begin
        i_if.raddr_valid = 1'b1;
        i_if.raddr       = 32'h10;
        i_if.rdata_ready = 1'b1;
        d_if.raddr_valid = 1'b0;
        d_if.raddr       = 32'h20;
        d_if.rdata_ready = 1'b1;
        m_if.raddr_ready = 1'b1;
        m_if.rdata_valid = 1'b0;
        m_if.rdata       = 32'h0;

        // Reset held for two cycles with a pending request: everything stays quiet.
        cyc();
        cyc();
        check_b("rst i_raddr_ready", i_if.raddr_ready, 1'b0);
        check_b("rst d_raddr_ready", d_if.raddr_ready, 1'b0);
        check_b("rst m_raddr_valid", m_if.raddr_valid, 1'b0);
        check_b("rst m_rdata_ready", m_if.rdata_ready, 1'b0);
        check_b("rst rdata_valids", i_if.rdata_valid | d_if.rdata_valid, 1'b0);

        // Release with both requesters waiting; I wins the first tie unless data priority.
        rst              = 1'b1;
        d_if.raddr_valid = 1'b1;
        #1;
        check_b("post-rst i_raddr_ready", i_if.raddr_ready, !CONT_OWNER[0]);

        for (int k = 0; k < 4; k++) begin
            xact("cont", CONT_OWNER[k] ? 32'h20 : 32'h10, CONT_OWNER[k], 32'hA000_0000 + k);
        end
        i_if.raddr_valid = 1'b0;
        d_if.raddr_valid = 1'b0;

        // Single instruction read.
        i_if.raddr_valid = 1'b1;
        i_if.raddr       = 32'h100;
        #1;
        xact("single_i", 32'h100, 1'b0, 32'hDEAD_BEEF);
        i_if.raddr_valid = 1'b0;

        // Address back-pressure, then data back-pressure from the data requester.
        d_if.raddr_valid = 1'b1;
        d_if.raddr       = 32'h44;
        m_if.raddr_ready = 1'b0;
        #1;
        check_b("bp grant d", d_if.raddr_ready, 1'b1);
        cyc();
        d_if.raddr_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_b("bp m_raddr_valid", m_if.raddr_valid, 1'b1);
            check_w("bp m_raddr", m_if.raddr, 32'h44);
            check_b("bp raddr_ready", i_if.raddr_ready | d_if.raddr_ready, 1'b0);
            cyc();
        end
        m_if.raddr_ready = 1'b1;
        cyc();
        m_if.rdata_valid = 1'b1;
        m_if.rdata       = 32'hCAFE_F00D;
        d_if.rdata_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_b("bp m_rdata_ready", m_if.rdata_ready, 1'b0);
            check_b("bp d_rdata_valid", d_if.rdata_valid, 1'b1);
            check_w("bp d_rdata", d_if.rdata, 32'hCAFE_F00D);
            check_b("bp i_rdata_valid", i_if.rdata_valid, 1'b0);
            cyc();
        end
        d_if.rdata_ready = 1'b1;
        #1;
        check_b("bp release m_rdata_ready", m_if.rdata_ready, 1'b1);
        cyc();

        // Memory keeps rdata_valid high in IDLE: nothing is accepted or forwarded.
        for (int k = 0; k < 2; k++) begin
            check_b("spur m_rdata_ready", m_if.rdata_ready, 1'b0);
            check_b("spur rdata_valids", i_if.rdata_valid | d_if.rdata_valid, 1'b0);
            check_b("spur m_raddr_valid", m_if.raddr_valid, 1'b0);
            cyc();
        end
        m_if.rdata_valid = 1'b0;

        // Reset during DATA abandons the read; the next request proceeds normally.
        i_if.raddr_valid = 1'b1;
        i_if.raddr       = 32'h200;
        #1;
        check_b("mid i_raddr_ready", i_if.raddr_ready, 1'b1);
        cyc();
        i_if.raddr_valid = 1'b0;
        cyc();
        m_if.rdata_valid = 1'b1;
        m_if.rdata       = 32'h5555_AAAA;
        #1;
        check_b("mid data i_rdata_valid", i_if.rdata_valid, 1'b1);
        rst = 1'b0;
        #1;
        check_b("mid rst m_rdata_ready", m_if.rdata_ready, 1'b0);
        check_b("mid rst i_rdata_valid", i_if.rdata_valid, 1'b0);
        cyc();
        rst              = 1'b1;
        m_if.rdata_valid = 1'b0;
        #1;
        check_b("after rst m_raddr_valid", m_if.raddr_valid, 1'b0);
        check_b("after rst rdata_valids", i_if.rdata_valid | d_if.rdata_valid, 1'b0);
        d_if.raddr_valid = 1'b1;
        d_if.raddr       = 32'h300;
        #1;
        xact("post_rst_d", 32'h300, 1'b1, 32'h1234_5678);
        d_if.raddr_valid = 1'b0;

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/read_arbiter.md
Name: read_arbiter

Overview:
- Shares one memory read port between the core's instruction-read (i_) and data-read (d_) channels.
- Sits between copperv's i_raddr/i_rdata and d_raddr/d_rdata valid/ready channels and a single-ported memory.
- Arbitration is 2-way round-robin.
- One read is outstanding at a time; read data is routed back to the requester that owns the transaction.

Parameters:
- bus_width, 32, width of address and data buses.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- i_raddr_valid  in  1  instruction read-address valid.
- i_raddr  in  bus_width  instruction read address.
- i_raddr_ready  out  1  instruction read-address accepted.
- i_rdata_valid  out  1  instruction read data valid.
- i_rdata  out  bus_width  instruction read data.
- i_rdata_ready  in  1  instruction requester ready for data.
- d_raddr_valid  in  1  data read-address valid.
- d_raddr  in  bus_width  data read address.
- d_raddr_ready  out  1  data read-address accepted.
- d_rdata_valid  out  1  data read data valid.
- d_rdata  out  bus_width  data read data.
- d_rdata_ready  in  1  data requester ready for data.
- m_raddr_valid  out  1  memory read-address valid.
- m_raddr  out  bus_width  memory read address.
- m_raddr_ready  in  1  memory accepted address.
- m_rdata_valid  in  1  memory read data valid.
- m_rdata  in  bus_width  memory read data.
- m_rdata_ready  out  1  arbiter ready for memory data.

Behaviour:
- Handshake: a transfer occurs on any channel in a cycle where valid and ready are both high. Once asserted, valid holds with stable payload until the transfer.
- States: IDLE, ADDR, DATA. Registers: state, owner (0=I, 1=D), last_grant, addr_q.
- Reset (rst=0 at a clk edge):
  - state=IDLE, owner=0, last_grant=1 (so I wins the first tie), addr_q=0.
  - All outputs low: m_raddr_valid, m_rdata_ready, i_/d_raddr_ready, i_/d_rdata_valid.
  - Reset mid-transaction abandons it without completing any handshake. The memory side must also be reset.
- IDLE:
  - i_raddr_ready/d_raddr_ready are combinational grants, at most one high.
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - On grant: addr_q <= granted address, owner <= granted ID, last_grant <= granted ID, go to ADDR.
  - No valid: stay in IDLE.
- ADDR:
  - m_raddr_valid=1, m_raddr=addr_q. Both raddr_ready outputs are 0.
  - On m_raddr_ready, go to DATA.
- DATA:
  - Owner's rdata_valid = m_rdata_valid; owner's rdata = m_rdata.
  - m_rdata_ready = owner's rdata_ready. The non-owner's rdata_valid is 0.
  - On m_rdata_valid & m_rdata_ready, go to IDLE.
- Latency:
  - Grant in cycle N; m_raddr_valid first high in cycle N+1.
  - Zero extra cycles on the data return path, which is combinational.
  - Minimum 3 cycles per transaction when the memory responds with 0-wait ready/valid.
- m_rdata_valid in IDLE or ADDR: ignored, with m_rdata_ready=0. No data is forwarded.
- Requester valid deasserting before grant is a protocol violation. The arbiter does not filter it.
- m_rdata is passed through unmodified. i_rdata/d_rdata may carry m_rdata at all times; only the valid bits are gated.

Optional Feature:
- Macro: READ_ARB_DATA_PRIO_EN.
- Defined: fixed priority. D always wins when both requesters are valid in IDLE; last_grant is unused.
- Undefined: round-robin as above.
- Ports and latency are identical in both builds.

Decomposition:
- Package copperv_pkg:
  - state encoding constants (IDLE, ADDR, DATA, 2 bits);
  - requester IDs (REQ_I=0, REQ_D=1).
- Sub-module rr_arbiter_2:
  - combinational 2-way grant from (req_i, req_d, last_grant) → one-hot grant;
  - honours READ_ARB_DATA_PRIO_EN.
- read_arbiter instantiates rr_arbiter_2 and holds the FSM and registers.

Test Plan:
- Reset: hold rst=0 for 2 cycles with i_raddr_valid=1 → all outputs 0. Release → i_raddr_ready=1 in the first cycle after reset.
- Single I read:
  - i_raddr=0x100, memory ready at once, data 0xDEADBEEF one cycle later.
  - Expect m_raddr=0x100 the cycle after grant, i_rdata_valid=1 with 0xDEADBEEF, d_rdata_valid=0 throughout.
- Contention, round-robin:
  - i and d both valid continuously (I=0x10, D=0x20).
  - Expect m_raddr sequence 0x10, 0x20, 0x10, 0x20, each returned only to its owner.
  - With READ_ARB_DATA_PRIO_EN: 0x20 first, and 0x20 repeatedly while d stays valid.
- Back-pressure:
  - m_raddr_ready low for 5 cycles → m_raddr_valid held, m_raddr stable, both raddr_ready=0.
  - Then d_rdata_ready=0 for 3 cycles with m_rdata_valid=1 → m_rdata_ready=0 and no state change until d_rdata_ready=1.
- Spurious data: m_rdata_valid=1 in IDLE → m_rdata_ready=0, i_/d_rdata_valid=0.
- Reset mid-DATA: rst=0 while in DATA → state returns to IDLE, all valids 0 next cycle. Next request after reset is granted normally.
